// File: rtl/bfloat16_act_lut.sv
// Pipelined bfloat16 odd-symmetric activation lookup with loadable per-function banks.
// Two-stage valid/ready stream: classify and index, then table read and sign restore.
module bfloat16_act_lut #(
    parameter int ADDR_W     = 5,
    parameter int FUNC_W     = 1,
    parameter int MANT_IDX_W = 2,
    parameter int EXP_MIN    = 121
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              in_load_enable,
    input  logic [FUNC_W-1:0] in_load_func,
    input  logic [ADDR_W-1:0] in_load_addr,
    input  logic [15:0]       in_load_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [15:0]       input_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       output_y
);

    localparam int         NUM_BANKS   = 2 ** FUNC_W;
    localparam int         NUM_ENTRIES = 2 ** ADDR_W;
    localparam int         SPAN_W      = ADDR_W - MANT_IDX_W;
    localparam logic [8:0] EXP_LO      = 9'(EXP_MIN);
    localparam logic [8:0] EXP_SAT     = 9'(EXP_MIN + 2 ** SPAN_W);

    typedef enum logic [2:0] {
        CLS_TABLE,
        CLS_SAT,
        CLS_NAN,
        CLS_ZERO,
        CLS_SMALL
    } cls_e;

    logic [15:0]       lut_q [NUM_BANKS][NUM_ENTRIES];
    logic [15:0]       lut_d [NUM_BANKS][NUM_ENTRIES];

    logic              s1_valid_q, s1_valid_d;
    logic [15:0]       s1_x_q,     s1_x_d;
    cls_e              s1_cls_q,   s1_cls_d;
    logic [ADDR_W-1:0] s1_idx_q,   s1_idx_d;
    logic [FUNC_W-1:0] s1_func_q,  s1_func_d;

    logic              out_valid_q, out_valid_d;
    logic [15:0]       output_y_q,  output_y_d;

    logic              en;
    logic [7:0]        in_exp;
    logic [6:0]        in_mant;
    logic [7:0]        exp_off;
    cls_e              in_cls;
    logic [ADDR_W-1:0] in_idx;
    logic [15:0]       entry;
    logic [15:0]       result;

    // Whole pipeline freezes only when a held result is not being taken.
    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign output_y  = output_y_q;

    always_comb begin
        in_exp  = input_x[14:7];
        in_mant = input_x[6:0];
        exp_off = in_exp - EXP_LO[7:0];
        if (in_exp == 8'hFF && in_mant != 7'd0) begin
            in_cls = CLS_NAN;
        end else if (in_exp == 8'd0) begin
            in_cls = CLS_ZERO;
        end else if ({1'b0, in_exp} < EXP_LO) begin
            in_cls = CLS_SMALL;
        end else if ({1'b0, in_exp} >= EXP_SAT || in_exp == 8'hFF) begin
            in_cls = CLS_SAT;
        end else begin
            in_cls = CLS_TABLE;
        end
        in_idx = (in_cls == CLS_SAT) ? '1
                                     : {exp_off[SPAN_W-1:0], in_mant[6 -: MANT_IDX_W]};
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_cls_d   = s1_cls_q;
        s1_idx_d   = s1_idx_q;
        s1_func_d  = s1_func_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d    = input_x;
                s1_cls_d  = in_cls;
                s1_idx_d  = in_idx;
                s1_func_d = in_func;
            end
        end
    end

    // Reads the registered table, so a same-cycle write is seen by the next sample only.
    always_comb begin
        entry = lut_q[s1_func_q][s1_idx_q];
        unique case (s1_cls_q)
            CLS_NAN:   result = 16'h7FC0;
            CLS_ZERO:  result = {s1_x_q[15], 15'h0000};
            CLS_SMALL: result = s1_x_q;
            default:   result = {s1_x_q[15] ^ entry[15], entry[14:0]};
        endcase
        out_valid_d = out_valid_q;
        output_y_d  = output_y_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                output_y_d = result;
            end
        end
    end

    always_comb begin
        lut_d = lut_q;
        if (in_load_enable) begin
            lut_d[in_load_func][in_load_addr] = in_load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= 16'h0000;
            s1_cls_q    <= CLS_ZERO;
            s1_idx_q    <= '0;
            s1_func_q   <= '0;
            out_valid_q <= 1'b0;
            output_y_q  <= 16'h0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_cls_q    <= s1_cls_d;
            s1_idx_q    <= s1_idx_d;
            s1_func_q   <= s1_func_d;
            out_valid_q <= out_valid_d;
            output_y_q  <= output_y_d;
        end
    end

    // NOTE: the table is deliberately reset; contents must read as zero after any reset.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int a = 0; a < NUM_ENTRIES; a++) begin
                    lut_q[b][a] <= 16'h0000;
                end
            end
        end else begin
            lut_q <= lut_d;
        end
    end

endmodule

// File: tb/tb_bfloat16_act_lut.sv
// Self-checking bench for bfloat16_act_lut: directed plan vectors, backpressure,
// mid-stream reset and a randomized stream scored against an arithmetic reference.
module tb_bfloat16_act_lut;

    localparam int ADDR_W     = 5;
    localparam int FUNC_W     = 1;
    localparam int MANT_IDX_W = 2;
    localparam int EXP_MIN    = 121;
    localparam int NB         = 2 ** FUNC_W;
    localparam int NE         = 2 ** ADDR_W;

    logic              clk;
    logic              rst_x;
    logic              in_load_enable;
    logic [FUNC_W-1:0] in_load_func;
    logic [ADDR_W-1:0] in_load_addr;
    logic [15:0]       in_load_data;
    logic              in_valid;
    logic              in_ready;
    logic [FUNC_W-1:0] in_func;
    logic [15:0]       input_x;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       output_y;

    bfloat16_act_lut #(
        .ADDR_W(ADDR_W), .FUNC_W(FUNC_W), .MANT_IDX_W(MANT_IDX_W), .EXP_MIN(EXP_MIN)
    ) dut (
        .clk(clk), .rst_x(rst_x),
        .in_load_enable(in_load_enable), .in_load_func(in_load_func),
        .in_load_addr(in_load_addr), .in_load_data(in_load_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func), .input_x(input_x),
        .out_valid(out_valid), .out_ready(out_ready), .output_y(output_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        int          acc;
    } exp_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        exp_q[$];
    logic [15:0] cur_exp;
    logic [15:0] mlut [NB][NE];
    int          cyc = 0;
    int          stall_lo = -1;
    int          stall_hi = -1;
    int          stalls = 0;
    bit          rand_ready = 0;
    bit          lat_chk = 0;
    bit          accepted;
    bit          hold_chk = 0;
    logic [15:0] hold_y;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: decode the bfloat16 fields arithmetically and look up the model table.
    function automatic logic [15:0] model(input logic [15:0] x, input int f);
        int e, m, idx;
        logic [15:0] ent;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 255 && m != 0) return 16'h7FC0;
        if (e == 0) return {x[15], 15'h0000};
        if (e < EXP_MIN) return x;
        if (e >= EXP_MIN + 2 ** (ADDR_W - MANT_IDX_W) || e == 255) idx = NE - 1;
        else idx = (e - EXP_MIN) * (2 ** MANT_IDX_W) + m / (2 ** (7 - MANT_IDX_W));
        ent = mlut[f][idx];
        return {x[15] ^ ent[15], ent[14:0]};
    endfunction

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t ex;
        @(negedge clk);
        if (hold_chk) begin
            check("stall_hold_y", output_y, hold_y);
            check("stall_hold_valid", {15'b0, out_valid}, 16'h0001);
        end
        hold_chk = out_valid && !out_ready;
        hold_y   = output_y;
        if (out_valid && !out_ready) begin
            stalls++;
            check("stall_in_ready", {15'b0, in_ready}, 16'h0000);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back('{y: cur_exp, acc: cyc});
            accepted = 1;
        end
        if (out_valid && out_ready) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_miss++;
                $error("FAIL spurious_out observed=%h expected=none", output_y);
            end
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("result", output_y, ex.y);
                if (lat_chk) check("latency", 16'(cyc - ex.acc), 16'd2);
            end
        end
        if (in_load_enable) mlut[int'(in_load_func)][int'(in_load_addr)] = in_load_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    task automatic send(input logic [15:0] x, input int f, input logic [15:0] expv);
        input_x  = x;
        in_func  = FUNC_W'(f);
        cur_exp  = expv;
        in_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) tick();
        n_vec++;
        assert (accepted) else begin
            n_miss++;
            $error("FAIL accept_timeout observed=%h expected=accepted", x);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_miss++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic load(input int f, input int a, input logic [15:0] d);
        in_load_enable = 1'b1;
        in_load_func   = FUNC_W'(f);
        in_load_addr   = ADDR_W'(a);
        in_load_data   = d;
        tick();
        in_load_enable = 1'b0;
    endtask

    initial begin
        rst_x = 1'b0;
        in_load_enable = 1'b0; in_load_func = '0; in_load_addr = '0; in_load_data = '0;
        in_valid = 1'b0; in_func = '0; input_x = '0; out_ready = 1'b1; cur_exp = '0;
        for (int b = 0; b < NB; b++) for (int a = 0; a < NE; a++) mlut[b][a] = 16'h0000;
        repeat (2) @(posedge clk);
        #2 rst_x = 1'b1;
        @(posedge clk);
        #1;
        check("reset_out_valid", {15'b0, out_valid}, 16'h0000);
        check("reset_output_y", output_y, 16'h0000);
        check("reset_in_ready", {15'b0, in_ready}, 16'h0001);

        // Load bank 0 and look up back-to-back.
        for (int k = 0; k < NE; k++) load(0, k, 16'h3C00 + 16'(k));
        lat_chk = 1;
        send(16'h3F81, 0, 16'h3C18);
        send(16'h4001, 0, 16'h3C1C);
        drain();

        // Odd symmetry and saturation, including infinities.
        send(16'hBF81, 0, 16'hBC18);
        send(16'h4101, 0, 16'h3C1F);
        send(16'h7F80, 0, 16'h3C1F);
        send(16'hFF80, 0, 16'hBC1F);
        drain();

        // Small pass-through, signed zero, denormal flush, NaN.
        send(16'h3C00, 0, 16'h3C00);
        send(16'h8000, 0, 16'h8000);
        send(16'h0001, 0, 16'h0000);
        send(16'h7FC1, 0, 16'h7FC0);
        drain();

        // Bank select, then a write colliding with the stage-2 read.
        for (int k = 0; k < NE; k++) load(1, k, 16'h4000 + 16'(k));
        send(16'h3F81, 1, 16'h4018);
        drain();
        send(16'h3F81, 1, 16'h4018);
        in_valid = 1'b0;
        load(1, 24, 16'h4100);
        send(16'h3F81, 1, 16'h4100);
        drain();
        lat_chk = 0;

        // Backpressure: three stalled cycles with the input held valid.
        stall_lo = cyc + 3;
        stall_hi = cyc + 6;
        stalls   = 0;
        send(16'h3F81, 0, 16'h3C18);
        send(16'h4001, 0, 16'h3C1C);
        send(16'hBF81, 0, 16'hBC18);
        send(16'h3E81, 0, 16'h3C10);
        drain();
        check("stall_cycles", 16'(stalls), 16'd3);

        // Randomized tables and stream with random backpressure.
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NE; a++) load(b, a, 16'($urandom));
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] x;
            int e, f;
            if ($urandom_range(0, 9) < 7) e = $urandom_range(EXP_MIN - 3, EXP_MIN + 10);
            else                          e = $urandom_range(0, 255);
            x = {1'($urandom), 8'(e), 7'($urandom)};
            f = $urandom_range(0, NB - 1);
            send(x, f, model(x, f));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        drain();
        rand_ready = 0;
        out_ready  = 1'b1;

        // Reset with two samples in flight.
        send(16'h3F81, 0, model(16'h3F81, 0));
        send(16'h4001, 0, model(16'h4001, 0));
        in_valid = 1'b0;
        #2 rst_x = 1'b0;
        #1;
        check("async_reset_out_valid", {15'b0, out_valid}, 16'h0000);
        check("async_reset_output_y", output_y, 16'h0000);
        exp_q.delete();
        hold_chk = 0;
        for (int b = 0; b < NB; b++) for (int a = 0; a < NE; a++) mlut[b][a] = 16'h0000;
        @(negedge clk);
        rst_x = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", {15'b0, in_ready}, 16'h0001);
        send(16'h3F81, 0, 16'h0000);
        send(16'h4001, 1, 16'h0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bfloat16_act_lut.md
Name: bfloat16_act_lut

Overview:
- Parametrised, pipelined successor to the single-function bfloat16 tanh LUT unit.
- Holds 2**FUNC_W independently loadable banks of odd-symmetric activation tables (e.g. tanh, softsign). Each bank is 2**ADDR_W entries.
- Processes one bfloat16 sample per cycle over a valid/ready stream, with a per-sample function select.
- Handles sign symmetry, small-input pass-through, saturation and IEEE special values in hardware.

Parameters:
- ADDR_W, 5, LUT address width; 2**ADDR_W entries per bank.
- FUNC_W, 1, function-select width; 2**FUNC_W banks.
- MANT_IDX_W, 2, mantissa MSBs used in the index (1..ADDR_W-1).
- EXP_MIN, 121, lowest biased exponent covered by the table.

Ports:
- clk  in  1  clock
- rst_x  in  1  asynchronous active-low reset
- in_load_enable  in  1  LUT write strobe
- in_load_func  in  FUNC_W  bank to write
- in_load_addr  in  ADDR_W  entry to write
- in_load_data  in  16  bfloat16 entry value
- in_valid  in  1  input sample valid
- in_ready  out  1  unit accepts the sample this cycle
- in_func  in  FUNC_W  bank used for this sample
- input_x  in  16  bfloat16 operand
- out_valid  out  1  output_y valid
- out_ready  in  1  downstream accepts output
- output_y  out  16  bfloat16 result

Behaviour:
- Clock and reset: single clock clk. Reset rst_x is asynchronous and active-low.
- Reset values: out_valid=0, output_y=16'h0000, all stage valids=0, all LUT entries=16'h0000. in_ready=1 after reset.
- Reset mid-operation: all in-flight samples are discarded and all LUT contents are lost.
- LUT write: when in_load_enable=1, bank[in_load_func][in_load_addr] <= in_load_data on the rising edge. The write is independent of the stream handshake.
- Read/write collision: a read of the same entry in the same cycle as a write returns the OLD value.
- Pipeline: 2 stages, one global enable en = !(out_valid && !out_ready). in_ready = en.
- A sample is accepted when in_valid && in_ready. Its result appears with out_valid 2 cycles later when there is no stall.
- Ordering: results stay in order and none are dropped or duplicated under any out_ready pattern. While stalled, output_y and out_valid hold.
- Stage 1 (register on accept): capture the sign s, biased exponent e=x[14:7], mantissa m=x[6:0] and func. Classify:
  - NaN: e=255 and m!=0.
  - ZERO: e=0. Denormals flush to a signed zero.
  - SMALL: 0<e<EXP_MIN.
  - SAT: e >= EXP_MIN + 2**(ADDR_W-MANT_IDX_W), or e=255 with m=0 (infinity).
  - TABLE: everything else.
  - Compute idx = {(e-EXP_MIN)[ADDR_W-MANT_IDX_W-1:0], m[6:7-MANT_IDX_W]}. SAT forces idx = all ones.
- Stage 2 (register when en): read LUT[func][idx] on the stage1->stage2 transfer cycle, then form the result:
  - NaN -> 16'h7FC0.
  - ZERO -> {s,15'h0}.
  - SMALL -> input_x unchanged (slope-1 region).
  - TABLE or SAT -> {s ^ entry[15], entry[14:0]}, i.e. odd symmetry.
- Bubbles: a stage holding no valid sample still advances when en=1. out_valid follows the stage-2 valid.

Test Plan:
- Load and lookup: reset, then load bank0 entry k = 16'h3C00+k for k=0..31. Stream 3F81, 4001 with func=0. Required: output_y = 3C18, then 3C1C, each 2 cycles after acceptance, back-to-back.
- Symmetry and saturation: stream BF81, 4101, 7F80, FF80. Required: BC18, 3C1F, 3C1F, BC1F.
- Special and small values: stream 3C00, 8000, 0001, 7FC1. Required: 3C00, 8000, 0000, 7FC0.
- Bank select and collision:
  - Load bank1 entry k = 16'h4000+k. Input 3F81 with func=1 -> 4018.
  - Rewrite bank1 addr 24 = 16'h4100 in the same cycle that 3F81/func=1 moves stage1->stage2 -> 4018. The next identical sample -> 4100.
- Backpressure: stream 4 samples with in_valid held high and out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 throughout the stall, output_y stable, all 4 results delivered in order, none duplicated.
- Reset mid-stream: assert rst_x low with 2 samples in flight. Required: out_valid=0 immediately (asynchronously) and a lookup after release returns 16'h0000 for TABLE inputs.
